req_arbiter: RTL and testbench
==============================

Name: req_arbiter

Overview:
- Shares one downstream resource between 8 requesters. Winner selection is the priority encoding of the request vector: bit 7 is highest priority, bit 0 is lowest.
- Registers a one-hot grant and its 3-bit index, holds the grant for one tenure, then re-arbitrates.
- A hold-time limit prevents a high-priority requester from starving lower ones.
- Sits between client request lines and the shared resource's select/mux logic.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 for this revision.
- ID_W, 3, width of the grant index; must equal clog2(N_REQ).
- MAX_HOLD, 16, maximum grant tenure in cycles; legal range 1..255.
- CNT_W, 8, tenure counter width; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- req, input, 8, request lines; level-sensitive, bit 7 is highest priority.
- done, input, 1, current owner releases the resource; sampled only in GRANT.
- gnt, output, 8, one-hot grant; all zero when no owner.
- gnt_id, output, 3, index of the current owner; 0 when gnt_valid=0.
- gnt_valid, output, 1, high while a grant is held.
- timeout, output, 1, one-cycle pulse when a tenure ended by hitting MAX_HOLD.

Behaviour:
- Reset (async, immediate on rst=1): state=IDLE; gnt=0, gnt_id=0, gnt_valid=0, timeout=0; tenure counter=0; last_owner=0. This also applies mid-tenure: the grant drops in the same cycle rst rises, with no RELEASE cycle.
- All outputs are registered.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If req!=0 at an edge, go to GRANT and latch the winner into gnt/gnt_id/gnt_valid. Latency is 1 cycle: req high before edge t gives gnt high after edge t.
  - If req==0, stay in IDLE.
- GRANT:
  - The counter starts at 0 on the first grant cycle and increments each cycle.
  - Release condition is any of: done=1; req[gnt_id]=0; counter==MAX_HOLD-1.
  - On release, go to RELEASE: clear gnt/gnt_valid/gnt_id, clear the counter, store last_owner=gnt_id.
  - Requests from non-owners during GRANT are ignored; there is no preemption.
- timeout:
  - Asserted during the RELEASE cycle only when the release was caused solely by the counter limit.
  - If done=1 or the owner's req drop coincides with the limit, timeout stays 0.
- RELEASE:
  - gnt=0 for exactly one cycle (dead cycle for the downstream mux to settle).
  - Arbitrates like IDLE: req!=0 goes to GRANT with a new winner; otherwise go to IDLE.
  - Minimum gap between two grants is 1 cycle.
- Sampling: req is sampled at the arbitration edge only. Pulses on req shorter than one cycle are not required to be seen.
- The same requester may be re-granted immediately after RELEASE if it still wins priority (fixed-priority mode).
- MAX_HOLD=1: every tenure is exactly 1 cycle; timeout pulses unless done or the owner's req drop ends it.
- Invariants: gnt is never multi-hot; gnt_valid==|gnt; gnt_id always matches gnt.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: rotating priority. After owner k, the priority order is k-1, k-2, ... wrapping modulo 8, with k lowest. Because last_owner resets to 0, the first arbitration after reset equals fixed priority.
- Undefined: fixed priority, 7 highest; last_owner is still stored but unused.

Decomposition:
- Package arb_pkg holds:
  - the state enum typedef (IDLE, GRANT, RELEASE);
  - constants N_REQ=8 and ID_W=3;
  - a one-hot-from-index helper function.
- Sub-module prio_pick, combinational:
  - inputs: req[7:0] and rotation base[2:0];
  - outputs: win_id[2:0] and win_valid;
  - with base=0 it is a plain 8:3 priority encoder (bit 7 highest).

Test Plan:
- Reset: hold rst=1 with req=8'hFF, then release rst → gnt=0 during reset; 1 cycle after release gnt=8'h80, gnt_id=7.
- Priority: req=8'b0010_0100 from IDLE → gnt=8'h20, gnt_id=5. Owner asserts done=1 → RELEASE (gnt=0) for 1 cycle, then gnt=8'h04, gnt_id=2.
- Timeout: MAX_HOLD=4, req=8'h01 held constant, done=0 → gnt=8'h01 for exactly 4 cycles, 1 dead cycle with timeout=1, then re-grant of 8'h01.
- Coincident release: with counter==MAX_HOLD-1 and done=1 in the same cycle → RELEASE with timeout=0.
- Owner drop / reset mid-tenure: the owner's req bit drops → release on the next edge. Asserting rst mid-grant clears gnt asynchronously within the same cycle.
- ARB_ROUND_ROBIN_EN: req=8'hFF held, done pulsed each tenure → grant order 7,6,5,...,0,7. Without the macro the order is 7,7,7.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way request arbiter.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // Expand a requester index into a one-hot grant vector.
  function automatic logic [N_REQ-1:0] onehot_from_id(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] r;
    r     = '0;
    r[id] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational rotating priority picker.
// Requester (base-1) mod 8 is highest priority and requester base is lowest;
// with base=0 this is a plain 8:3 priority encoder with bit 7 highest.
module prio_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  base,
  output logic [ID_W-1:0]  win_id,
  output logic             win_valid
);

  logic [N_REQ-1:0] rot;
  logic [ID_W-1:0]  pos;
  logic [ID_W-1:0]  slot;

  // Rotate so the highest-priority requester lands on bit 7, encode, rotate back.
  always_comb begin
    rot  = '0;
    pos  = '0;
    slot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      slot      = ID_W'(i) - base;
      rot[slot] = req[i];
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (rot[i]) pos = ID_W'(i);
    end
    win_valid = |req;
    win_id    = pos + base;
  end

endmodule

// File: rtl/req_arbiter.sv
// 8-requester arbiter with registered one-hot grant, bounded tenure and a
// one-cycle dead slot between grants.
// Build option: define ARB_ROUND_ROBIN_EN for rotating priority after each
// owner; otherwise fixed priority with requester 7 highest.
module req_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  last_owner_q, last_owner_d;

  logic [ID_W-1:0]  base;
  logic [ID_W-1:0]  win_id;
  logic             win_valid;
  logic             owner_req;
  logic             at_limit;

  // Rotation base follows the previous owner only in round-robin builds.
  assign base = last_owner_q & {ID_W{RR_EN}};

  prio_pick u_prio_pick (
    .req       (req),
    .base      (base),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  assign owner_req = req[gnt_id_q];
  assign at_limit  = (cnt_q == CNT_W'(MAX_HOLD - 1));

  // Next-state and registered-output logic; timeout only when the limit alone ends a tenure.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    gnt_id_d     = gnt_id_q;
    gnt_valid_d  = gnt_valid_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    timeout_d    = 1'b0;
    case (state_q)
      IDLE, RELEASE: begin
        cnt_d = '0;
        if (win_valid) begin
          state_d     = GRANT;
          gnt_d       = onehot_from_id(win_id);
          gnt_id_d    = win_id;
          gnt_valid_d = 1'b1;
        end else begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_id_d    = '0;
          gnt_valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (done || !owner_req || at_limit) begin
          state_d      = RELEASE;
          gnt_d        = '0;
          gnt_id_d     = '0;
          gnt_valid_d  = 1'b0;
          cnt_d        = '0;
          last_owner_d = gnt_id_q;
          timeout_d    = at_limit && !done && owner_req;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_id_d    = '0;
        gnt_valid_d = 1'b0;
        cnt_d       = '0;
      end
    endcase
  end

  // State and output registers; reset drops the grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      gnt_id_q     <= '0;
      gnt_valid_q  <= 1'b0;
      timeout_q    <= 1'b0;
      cnt_q        <= '0;
      last_owner_q <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      gnt_id_q     <= gnt_id_d;
      gnt_valid_q  <= gnt_valid_d;
      timeout_q    <= timeout_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_req_arbiter.sv
// Directed testbench for req_arbiter (tenure limit set to 4 cycles).
module tb_req_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int checks;
  int errors;

  req_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1);
  end

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drain to IDLE with no requests.
  task automatic go_idle();
    req  = 8'h00;
    done = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = 8'hFF;
    done = 1'b0;
    tick();
    tick();
    checks++;
    if (gnt !== 8'h00) begin
      errors++; $display("FAIL reset_gnt got %h exp 00", gnt);
    end
    checks++;
    if (gnt_valid !== 1'b0 || gnt_id !== 3'd0 || timeout !== 1'b0) begin
      errors++; $display("FAIL reset_outs got v=%b id=%0d to=%b exp v=0 id=0 to=0", gnt_valid, gnt_id, timeout);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (gnt !== 8'h80 || gnt_id !== 3'd7 || gnt_valid !== 1'b1) begin
      errors++; $display("FAIL reset_first_grant got %h/%0d/%b exp 80/7/1", gnt, gnt_id, gnt_valid);
    end
    go_idle();
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
      errors++; $display("FAIL idle_after_drop got %h/%b exp 00/0", gnt, gnt_valid);
    end
  endtask

  task automatic test_priority();
    req = 8'b0010_0100;
    tick();
    checks++;
    if (gnt !== 8'h20 || gnt_id !== 3'd5 || gnt_valid !== 1'b1) begin
      errors++; $display("FAIL prio_first got %h/%0d/%b exp 20/5/1", gnt, gnt_id, gnt_valid);
    end
    req  = 8'b0000_0100;
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL prio_release got %h/%b/%b exp 00/0/0", gnt, gnt_valid, timeout);
    end
    tick();
    checks++;
    if (gnt !== 8'h04 || gnt_id !== 3'd2 || gnt_valid !== 1'b1) begin
      errors++; $display("FAIL prio_second got %h/%0d/%b exp 04/2/1", gnt, gnt_id, gnt_valid);
    end
    go_idle();
  endtask

  task automatic test_timeout();
    req = 8'h01;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (gnt !== 8'h01 || gnt_id !== 3'd0 || timeout !== 1'b0) begin
        errors++; $display("FAIL timeout_hold_c%0d got %h/%0d/%b exp 01/0/0", c, gnt, gnt_id, timeout);
      end
    end
    tick();
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_dead got %h/%b/%b exp 00/0/1", gnt, gnt_valid, timeout);
    end
    tick();
    checks++;
    if (gnt !== 8'h01 || timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_regrant got %h/%b exp 01/0", gnt, timeout);
    end
    go_idle();
  endtask

  task automatic test_coincident();
    req = 8'h01;
    tick();
    tick();
    tick();
    tick();
    checks++;
    if (gnt !== 8'h01) begin
      errors++; $display("FAIL coinc_hold got %h exp 01", gnt);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (gnt !== 8'h00 || timeout !== 1'b0) begin
      errors++; $display("FAIL coinc_release got %h/%b exp 00/0", gnt, timeout);
    end
    go_idle();
  endtask

  task automatic test_owner_drop();
    req = 8'h22;
    tick();
    checks++;
    if (gnt !== 8'h20 || gnt_id !== 3'd5) begin
      errors++; $display("FAIL drop_grant got %h/%0d exp 20/5", gnt, gnt_id);
    end
    req = 8'h02;
    tick();
    checks++;
    if (gnt !== 8'h00 || timeout !== 1'b0) begin
      errors++; $display("FAIL drop_release got %h/%b exp 00/0", gnt, timeout);
    end
    tick();
    checks++;
    if (gnt !== 8'h02 || gnt_id !== 3'd1) begin
      errors++; $display("FAIL drop_regrant got %h/%0d exp 02/1", gnt, gnt_id);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_id !== 3'd0) begin
      errors++; $display("FAIL async_reset got %h/%b/%0d exp 00/0/0", gnt, gnt_valid, gnt_id);
    end
    tick();
    rst = 1'b0;
    go_idle();
  endtask

  task automatic test_order();
    logic [2:0] exp_id [9];
    for (int k = 0; k < 9; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_id[k] = 3'(7 - (k % 8));
`else
      exp_id[k] = 3'd7;
`endif
    end
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      checks++;
      if (gnt_id !== exp_id[k] || gnt_valid !== 1'b1) begin
        errors++; $display("FAIL order_%0d got %0d/%b exp %0d/1", k, gnt_id, gnt_valid, exp_id[k]);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
    end
    go_idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    req    = 8'h00;
    done   = 1'b0;
    test_reset();
    test_priority();
    test_timeout();
    test_coincident();
    test_owner_drop();
    test_order();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
